// File: rtl/serial_sub_8_if.sv
// rtl/serial_sub_8_if.sv - start/done handshake and operand/result bundle for serial_sub_8
interface serial_sub_8_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, borrow, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, borrow, ovf
  );
endinterface

// File: rtl/serial_sub_8.sv
// rtl/serial_sub_8.sv - bit-serial subtractor, diff = a - b - bin, one bit per clock LSB first
module serial_sub_8 #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_sub_8_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE_ST} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;
  logic             ovf_r;

  logic d;
  logic br_nxt;
  logic last;

  assign d      = a_sr[0] ^ b_sr[0] ^ br;
  assign br_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last)      state_nxt = DONE_ST;
      DONE_ST: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = (state != IDLE);
    bus.done   = (state == DONE_ST);
    bus.diff   = diff_r;
    bus.borrow = borrow_r;
    bus.ovf    = ovf_r;
  end

  // Results only move on the completion edge so they hold through IDLE and the next operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res      <= '0;
      cnt      <= '0;
      br       <= 1'b0;
      diff_r   <= '0;
      borrow_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr <= bus.a;
            b_sr <= bus.b;
            br   <= bus.bin;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          res  <= {d, res[WIDTH-2:1]};
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= br_nxt;
          cnt  <= cnt + CW'(1);
          if (last) begin
            diff_r   <= {d, res};
            borrow_r <= br_nxt;
            // br is still the borrow into the MSB on this edge
            ovf_r    <= br ^ br_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_sub_8.sv
// tb/tb_serial_sub_8.sv - scoreboard bench for serial_sub_8
module tb_serial_sub_8;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   n_done;
  logic [9:0] sb[$];

  serial_sub_8_if #(.WIDTH(8)) ifc ();

  serial_sub_8 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // returns {ovf, borrow, diff}
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    logic [8:0] u;
    int sa;
    int sb_v;
    int r;
    logic o;
    u    = {1'b0, a} - {1'b0, b} - {8'd0, bin};
    sa   = (a >= 8'd128) ? int'(a) - 256 : int'(a);
    sb_v = (b >= 8'd128) ? int'(b) - 256 : int'(b);
    r    = sa - sb_v - int'(bin);
    o    = (r < -128) || (r > 127);
    return {o, u[8], u[7:0]};
  endfunction

  always @(negedge clk) begin
    if (ifc.done) begin
      logic [9:0] e;
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("diff", ifc.diff, e[7:0]);
        check("borrow", ifc.borrow, e[8]);
        check("ovf", ifc.ovf, e[9]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller 1ns after the accepting edge E0.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit push);
    ifc.start = 1'b1;
    ifc.a     = a;
    ifc.b     = b;
    ifc.bin   = bin;
    if (push) sb.push_back(model(a, b, bin));
    tick();
    ifc.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20 && !ifc.done; i++) tick();
    check({tag, "_done_seen"}, ifc.done, 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] e;
    n_checks  = 0;
    n_fail    = 0;
    n_done    = 0;
    rst_n     = 1'b0;
    ifc.start = 1'b0;
    ifc.a     = '0;
    ifc.b     = '0;
    ifc.bin   = 1'b0;
    tick();
    tick();
    check("rst_busy", ifc.busy, 0);
    check("rst_done", ifc.done, 0);
    check("rst_diff", ifc.diff, 0);
    check("rst_borrow", ifc.borrow, 0);
    check("rst_ovf", ifc.ovf, 0);
    rst_n = 1'b1;
    tick();

    // 1: latency and busy/done timing
    start_op(8'h77, 8'h55, 1'b0, 1'b1);
    for (int k = 0; k <= 9; k++) begin
      check($sformatf("t1_busy_e%0d", k), ifc.busy, (k <= 8) ? 1 : 0);
      check($sformatf("t1_done_e%0d", k), ifc.done, (k == 8) ? 1 : 0);
      tick();
    end

    // 2: borrow out, results hold in IDLE
    start_op(8'h00, 8'h01, 1'b0, 1'b1);
    wait_done("t2");
    e = model(8'h00, 8'h01, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("t2_hold_diff", ifc.diff, e[7:0]);
      check("t2_hold_borrow", ifc.borrow, e[8]);
      check("t2_hold_ovf", ifc.ovf, e[9]);
      tick();
    end

    // 3: signed overflow
    start_op(8'h80, 8'h01, 1'b0, 1'b1);
    wait_done("t3");

    // 4: start held high, back-to-back; operands changed after E0
    ifc.start = 1'b1;
    ifc.a     = 8'h56;
    ifc.b     = 8'h61;
    ifc.bin   = 1'b1;
    sb.push_back(model(8'h56, 8'h61, 1'b1));
    tick();
    ifc.a   = 8'h10;
    ifc.b   = 8'h10;
    ifc.bin = 1'b0;
    sb.push_back(model(8'h10, 8'h10, 1'b0));
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 8)  check("t4_done_e8", ifc.done, 1);
      if (k == 9)  check("t4_busy_e9", ifc.busy, 0);
      if (k == 10) check("t4_busy_e10", ifc.busy, 1);
    end
    ifc.start = 1'b0;
    wait_done("t4b");

    // 5: start re-pulse while busy is ignored
    start_op(8'hEA, 8'hD5, 1'b0, 1'b1);
    tick();
    ifc.start = 1'b1;
    ifc.a     = 8'hFF;
    ifc.b     = 8'h00;
    tick();
    ifc.start = 1'b0;
    wait_done("t5");
    for (int k = 0; k < 3; k++) begin
      check("t5_idle_busy", ifc.busy, 0);
      tick();
    end

    // 6: reset mid-operation aborts, then a fresh operation
    start_op(8'h33, 8'h11, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("t6_rst_busy", ifc.busy, 0);
    check("t6_rst_done", ifc.done, 0);
    check("t6_rst_diff", ifc.diff, 0);
    check("t6_rst_borrow", ifc.borrow, 0);
    check("t6_rst_ovf", ifc.ovf, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      check("t6_no_done", ifc.done, 0);
      tick();
    end
    start_op(8'h85, 8'hFF, 1'b0, 1'b1);
    wait_done("t6b");
    tick();

    check("sb_empty", sb.size(), 0);
    check("done_count", n_done, 7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
